reverb_damp_filter: RTL
=======================

REVERB_DAMP_FILTER -- requirements
Module: reverb_damp_filter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width (signed two's complement).
REQ-002 SHALL have parameter COEF_WIDTH, default 5, coefficient width (unsigned, Q0.5: value/32).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port clear  input  1  synchronous flush of filter state and any in-flight sample.
REQ-006 SHALL have port damp  input  COEF_WIDTH  low-pass coefficient; 0 holds state, 31 gives near pass-through.
REQ-007 SHALL have port feedback_gain  input  COEF_WIDTH  output scale coefficient.
REQ-008 SHALL have port inpvalid  input  1  sample-offered strobe from the reverb core.
REQ-009 SHALL have port din  input  DATA_WIDTH  signed sample from the reverb core.
REQ-010 SHALL have port input_ready  output  1  block can accept a sample.
REQ-011 SHALL have port outvalid  output  1  one-cycle strobe marking a new dout.
REQ-012 SHALL have port dout  output  DATA_WIDTH  signed damped feedback sample; held between strobes.

Function
REQ-013 SHALL accept a sample only on a rising edge where inpvalid=1 and input_ready=1 (acceptance edge E0); at E0 it SHALL capture din, damp, feedback_gain.
REQ-014 SHALL implement FSM IDLE -> DIFF -> STEP -> SCALE -> IDLE, one state per cycle; IDLE exits only on acceptance.
REQ-015 SHALL drive input_ready=1 only in IDLE; inpvalid outside IDLE SHALL be ignored, with no queuing.
REQ-016 DIFF SHALL form diff = x - y (DATA_WIDTH+1 bits signed), where y is the stored filter state.
REQ-017 STEP SHALL form y_new = y + (diff*damp >>> 5), with arithmetic shift (floor), and update y <= y_new.
REQ-018 SCALE SHALL register dout = (y_new*feedback_gain) >>> 5 (floor) and assert outvalid=1 for exactly that one cycle.
REQ-019 Latency: outvalid and dout SHALL update at edge E3; input_ready SHALL be 1 again from E3, so the next acceptance is possible at E4 at the earliest.
REQ-020 Intermediates SHALL be wide enough that no overflow occurs.
REQ-021 y and dout SHALL saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-022 damp=0 SHALL leave y unchanged; feedback_gain=0 SHALL give dout=0.
REQ-023 Between strobes, dout SHALL hold its last value and outvalid SHALL be 0.
REQ-024 clear=1 at any edge SHALL zero y, force state IDLE, and suppress any pending outvalid; dout SHALL hold its value.
REQ-025 clear and inpvalid in the same cycle: clear SHALL win and the sample SHALL be dropped.

Reset
REQ-026 Reset=1 at a rising edge SHALL force: state IDLE, y=0, dout=0, outvalid=0, input_ready=1.
REQ-027 Reset SHALL take priority over clear and over the handshake.
REQ-028 Reset mid-operation SHALL abort the sample with no outvalid.
REQ-029 After reset deassertion, the first acceptance SHALL be possible on the next edge.

Verification
REQ-030 SHALL check reset: Reset high 2 cycles -> input_ready=1, outvalid=0, dout=0.
REQ-031 SHALL check step response: y=0, damp=16, gain=31, din=1000 -> outvalid at E3, dout=484; a second din=1000 -> dout=726 (y=750).
REQ-032 SHALL check negative full scale: y=0, damp=31, gain=16, din=-32768 -> y=-31744, dout=-15872.
REQ-033 SHALL check a held inpvalid: inpvalid held high continuously -> acceptances exactly every 4 cycles, one outvalid per acceptance, input_ready low in DIFF/STEP/SCALE.
REQ-034 SHALL check clear mid-operation: clear asserted in STEP -> no outvalid, input_ready=1 next cycle, next din=1000 (damp=16, gain=31) -> dout=484.
REQ-035 SHALL check zero coefficients: damp=0 with any din -> dout unchanged at 0 from reset; gain=0 -> dout=0 with outvalid still pulsed.

Source files
------------

// File: rtl/reverb_damp_filter.sv
// One-pole low-pass damping stage for a reverb feedback path.
// Each accepted sample goes IDLE -> DIFF -> STEP -> SCALE; dout is output-scaled filter state.
module reverb_damp_filter #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         clear,
    input  logic [COEF_WIDTH-1:0]        damp,
    input  logic [COEF_WIDTH-1:0]        feedback_gain,
    input  logic                         inpvalid,
    input  logic signed [DATA_WIDTH-1:0] din,
    output logic                         input_ready,
    output logic                         outvalid,
    output logic signed [DATA_WIDTH-1:0] dout
);

    localparam int DW1 = DATA_WIDTH + 1;
    // Product width: a 17-bit difference times a 6-bit (zero-extended) coefficient, plus headroom.
    localparam int PW  = DATA_WIDTH + COEF_WIDTH + 2;

    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIFF  = 2'd1,
        S_STEP  = 2'd2,
        S_SCALE = 2'd3
    } state_t;

    state_t                         r_state;
    logic                           r_ready;
    logic                           r_outvalid;
    logic signed [DATA_WIDTH-1:0]   r_dout;
    logic signed [DATA_WIDTH-1:0]   r_x;
    logic signed [DATA_WIDTH-1:0]   r_y;
    logic signed [DW1-1:0]          r_diff;
    logic [COEF_WIDTH-1:0]          r_damp;
    logic [COEF_WIDTH-1:0]          r_gain;

    logic signed [PW-1:0]           w_step_prod;
    logic signed [PW-1:0]           w_step_sh;
    logic signed [PW-1:0]           w_y_sum;
    logic signed [PW-1:0]           w_out_prod;
    logic signed [PW-1:0]           w_out_sh;

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [PW-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[DATA_WIDTH-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[DATA_WIDTH-1:0];
        else
            return v[DATA_WIDTH-1:0];
    endfunction

    // Coefficients are unsigned fractions: zero-extend before the signed multiply.
    assign w_step_prod = PW'(r_diff) * PW'($signed({1'b0, r_damp}));
    assign w_step_sh   = w_step_prod >>> COEF_WIDTH;
    assign w_y_sum     = PW'(r_y) + w_step_sh;
    assign w_out_prod  = PW'(r_y) * PW'($signed({1'b0, r_gain}));
    assign w_out_sh    = w_out_prod >>> COEF_WIDTH;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_outvalid <= 1'b0;
            r_dout     <= '0;
            r_y        <= '0;
            r_x        <= '0;
            r_diff     <= '0;
            r_damp     <= '0;
            r_gain     <= '0;
        end else if (clear) begin
            // Flush drops the in-flight sample but keeps the last published dout.
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_outvalid <= 1'b0;
            r_y        <= '0;
        end else begin
            r_outvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (inpvalid) begin
                        r_x     <= din;
                        r_damp  <= damp;
                        r_gain  <= feedback_gain;
                        r_state <= S_DIFF;
                        r_ready <= 1'b0;
                    end
                end
                S_DIFF: begin
                    r_diff  <= DW1'(r_x) - DW1'(r_y);
                    r_state <= S_STEP;
                end
                S_STEP: begin
                    r_y     <= sat(w_y_sum);
                    r_state <= S_SCALE;
                end
                S_SCALE: begin
                    r_dout     <= sat(w_out_sh);
                    r_outvalid <= 1'b1;
                    r_state    <= S_IDLE;
                    r_ready    <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign input_ready = r_ready;
    assign outvalid    = r_outvalid;
    assign dout        = r_dout;

endmodule
